// File: rtl/divider_17_9bit_pkg.sv
// Shared widths, FSM encodings and result payload for the 17/9-bit signed divider.
package divider_17_9bit_pkg;

    localparam int unsigned DIV_N = 17;           // dividend / quotient width
    localparam int unsigned DIV_M = 9;            // divisor / remainder width
    localparam int unsigned DIV_R = DIV_M + 1;    // trial-subtraction width
    localparam int unsigned CNT_W = $clog2(DIV_N);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] DIV  = 2'b01;
    localparam logic [1:0] FIX  = 2'b10;

    // Saturation limits used for divide-by-zero and the single overflow case
    localparam logic [DIV_N-1:0] SAT_POS = {1'b0, {(DIV_N-1){1'b1}}};
    localparam logic [DIV_N-1:0] SAT_NEG = ~SAT_POS;

    typedef struct packed {
        logic [DIV_N-1:0] quotient;
        logic [DIV_M-1:0] remainder;
        logic             div_by_zero;
        logic             overflow;
    } div_result_t;

    // Two's-complement negation at dividend width
    function automatic logic [DIV_N-1:0] neg_n(input logic [DIV_N-1:0] x);
        return ~x + DIV_N'(1);
    endfunction

    // Two's-complement negation at divisor width
    function automatic logic [DIV_M-1:0] neg_m(input logic [DIV_M-1:0] x);
        return ~x + DIV_M'(1);
    endfunction

endpackage

// File: rtl/divider_17_9bit_if.sv
// start/data_valid handshake bus between a requester and the divider.
interface divider_17_9bit_if;
    import divider_17_9bit_pkg::*;

    logic             start;
    logic [DIV_N-1:0] in_0;
    logic [DIV_M-1:0] in_1;
    logic             busy;
    logic             data_valid;
    logic [DIV_N-1:0] quotient;
    logic [DIV_M-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, in_0, in_1,
        input  busy, data_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, in_0, in_1,
        output busy, data_valid, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/N_bit_adder.sv
// Plain N-bit wrap-around adder; carry out is not needed by its users.
module N_bit_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/divider_17_9bit.sv
// Sequential signed restoring divider: 17-bit dividend / 9-bit divisor,
// one quotient bit per clock, fixed N+1 cycle latency after start.
module divider_17_9bit
    import divider_17_9bit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    divider_17_9bit_if.slave    bus
);

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    // Dividend magnitude; MSBs shift out into the remainder while quotient bits shift in
    logic [DIV_N-1:0] dvd_q,     dvd_d;
    // Partial remainder is always below |divisor| <= 256, so M bits hold it between steps
    logic [DIV_M-1:0] rem_q,     rem_d;
    logic [DIV_R-1:0] neg_dvs_q, neg_dvs_d;
    logic             sign_a_q,  sign_a_d;
    logic             sign_b_q,  sign_b_d;
    logic             busy_q,    busy_d;
    logic             valid_q,   valid_d;
    div_result_t      res_q,     res_d;

    logic [DIV_R-1:0] rem_shift_c;
    logic [DIV_R-1:0] diff_c;
    logic [DIV_M-1:0] dvs_mag_c;
    logic             dvs_zero_c;
    logic             q_neg_c;
    logic             ovf_c;

    assign rem_shift_c = {rem_q, dvd_q[DIV_N-1]};
    assign dvs_mag_c   = bus.in_1[DIV_M-1] ? neg_m(bus.in_1) : bus.in_1;
    // The negated magnitude is zero exactly when the divisor is zero
    assign dvs_zero_c  = (neg_dvs_q == '0);
    assign q_neg_c     = sign_a_q ^ sign_b_q;
    // Only -2^(N-1) / -1 yields a magnitude of 2^(N-1) with a positive sign
    assign ovf_c       = !dvs_zero_c && dvd_q[DIV_N-1] && !q_neg_c;

    // Trial subtraction: shifted remainder plus negated divisor magnitude
    N_bit_adder #(.N(DIV_R)) u_trial (
        .a_i   (rem_shift_c),
        .b_i   (neg_dvs_q),
        .sum_o (diff_c)
    );

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        neg_dvs_d = neg_dvs_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        res_d     = res_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d     = bus.in_0[DIV_N-1] ? neg_n(bus.in_0) : bus.in_0;
                    neg_dvs_d = ~{1'b0, dvs_mag_c} + DIV_R'(1);
                    sign_a_d  = bus.in_0[DIV_N-1];
                    sign_b_d  = bus.in_1[DIV_M-1];
                    rem_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = DIV;
                end
            end

            DIV: begin
                if (!diff_c[DIV_R-1]) begin
                    rem_d = diff_c[DIV_M-1:0];
                    dvd_d = {dvd_q[DIV_N-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift_c[DIV_M-1:0];
                    dvd_d = {dvd_q[DIV_N-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_N - 1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (dvs_zero_c) begin
                    res_d.quotient    = sign_a_q ? SAT_NEG : SAT_POS;
                    res_d.remainder   = '0;
                    res_d.div_by_zero = 1'b1;
                    res_d.overflow    = 1'b0;
                end else if (ovf_c) begin
                    res_d.quotient    = SAT_POS;
                    res_d.remainder   = '0;
                    res_d.div_by_zero = 1'b0;
                    res_d.overflow    = 1'b1;
                end else begin
                    res_d.quotient    = q_neg_c  ? neg_n(dvd_q) : dvd_q;
                    res_d.remainder   = sign_a_q ? neg_m(rem_q) : rem_q;
                    res_d.div_by_zero = 1'b0;
                    res_d.overflow    = 1'b0;
                end
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            neg_dvs_q <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            neg_dvs_q <= neg_dvs_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            res_q     <= res_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.data_valid  = valid_q;
    assign bus.quotient    = res_q.quotient;
    assign bus.remainder   = res_q.remainder;
    assign bus.div_by_zero = res_q.div_by_zero;
    assign bus.overflow    = res_q.overflow;

endmodule

// File: tb/tb_divider_17_9bit.sv
// Self-checking bench for divider_17_9bit: directed table, corner sequences, random vs. arithmetic model.
module tb_divider_17_9bit;

    logic clk = 1'b0;
    logic reset;

    divider_17_9bit_if bus ();

    divider_17_9bit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        bit dz;
        bit ov;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: integer division truncates toward zero, % takes the dividend's sign
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output bit dz, output bit ov);
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            dz = 1'b1;
            r  = 0;
            q  = (a >= 0) ? 65535 : -65536;
        end else if (a == -65536 && b == -1) begin
            ov = 1'b1;
            q  = 65535;
            r  = 0;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int act_q();
        return int'($signed(bus.quotient));
    endfunction

    function automatic int act_r();
        return int'($signed(bus.remainder));
    endfunction

    // One division from idle; optionally pokes start while busy with different operands
    task automatic run_div(input int a, input int b, input int eq, input int er,
                           input bit edz, input bit eov, input bit poke, input string tag);
        int k;
        bit busy_ok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_0  = 17'(a);
        bus.in_1  = 9'(b);
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_0  = 17'($urandom);
        bus.in_1  = 9'($urandom);
        k = 0;
        busy_ok = 1'b1;
        while (!bus.data_valid && k < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (poke && k == 5) begin
                bus.start = 1'b1;
                bus.in_0  = 17'($urandom);
                bus.in_1  = 9'($urandom_range(1, 255));
            end
            if (poke && k == 6) bus.start = 1'b0;
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, k, 18);
        chk({tag, " busy_during"}, int'(busy_ok), 1);
        chk({tag, " busy_at_valid"}, int'(bus.busy), 0);
        chk({tag, " quotient"}, act_q(), eq);
        chk({tag, " remainder"}, act_r(), er);
        chk({tag, " div_by_zero"}, int'(bus.div_by_zero), int'(edz));
        chk({tag, " overflow"}, int'(bus.overflow), int'(eov));
        @(negedge clk);
        chk({tag, " valid_pulse"}, int'(bus.data_valid), 0);
        chk({tag, " busy_after"}, int'(bus.busy), 0);
        chk({tag, " quotient_held"}, act_q(), eq);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int q, r;
        bit dz, ov;
        int bb_a[4];
        int bb_b[4];
        int last_cyc;

        vecs[0]  = '{a: 1000,   b: 7,    q: 142,    r: 6,   dz: 0, ov: 0};
        vecs[1]  = '{a: -1000,  b: 7,    q: -142,   r: -6,  dz: 0, ov: 0};
        vecs[2]  = '{a: 1000,   b: -7,   q: -142,   r: 6,   dz: 0, ov: 0};
        vecs[3]  = '{a: -1000,  b: -7,   q: 142,    r: -6,  dz: 0, ov: 0};
        vecs[4]  = '{a: 65535,  b: 255,  q: 257,    r: 0,   dz: 0, ov: 0};
        vecs[5]  = '{a: -65536, b: -1,   q: 65535,  r: 0,   dz: 0, ov: 1};
        vecs[6]  = '{a: -65536, b: 1,    q: -65536, r: 0,   dz: 0, ov: 0};
        vecs[7]  = '{a: 500,    b: 0,    q: 65535,  r: 0,   dz: 1, ov: 0};
        vecs[8]  = '{a: -500,   b: 0,    q: -65536, r: 0,   dz: 1, ov: 0};
        vecs[9]  = '{a: 65535,  b: -256, q: -255,   r: 255, dz: 0, ov: 0};
        vecs[10] = '{a: -65536, b: -256, q: 256,    r: 0,   dz: 0, ov: 0};
        vecs[11] = '{a: -1,     b: 255,  q: 0,      r: -1,  dz: 0, ov: 0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in_0  = '0;
        bus.in_1  = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset data_valid", int'(bus.data_valid), 0);
        chk("reset quotient", act_q(), 0);
        chk("reset remainder", act_r(), 0);
        chk("reset div_by_zero", int'(bus.div_by_zero), 0);
        chk("reset overflow", int'(bus.overflow), 0);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov,
                    1'b0, $sformatf("vec%0d", i));
        end

        // start pulse while busy must not disturb the running division or queue a new one
        run_div(1000, 7, 142, 6, 1'b0, 1'b0, 1'b1, "poke");

        // Reset at cycle 8 of a division aborts it and clears the outputs
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_0  = 17'(12345);
        bus.in_1  = 9'(-3);
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (k < 8) begin
            @(negedge clk);
            k++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort data_valid", int'(bus.data_valid), 0);
        chk("abort busy", int'(bus.busy), 0);
        chk("abort quotient", act_q(), 0);
        chk("abort remainder", act_r(), 0);
        chk("abort div_by_zero", int'(bus.div_by_zero), 0);
        chk("abort overflow", int'(bus.overflow), 0);
        run_div(-1000, -7, 142, -6, 1'b0, 1'b0, 1'b0, "after_abort");

        // Reset and start together: reset wins, nothing is captured
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.in_0  = 17'(100);
        bus.in_1  = 9'(3);
        @(negedge clk);
        chk("rst_start busy", int'(bus.busy), 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst_start busy_after", int'(bus.busy), 0);
        chk("rst_start data_valid", int'(bus.data_valid), 0);

        // Back-to-back with start held high, new operands presented in each data_valid cycle
        for (int i = 0; i < 4; i++) begin
            bb_a[i] = int'($urandom_range(0, 131071)) - 65536;
            bb_b[i] = int'($urandom_range(0, 511)) - 256;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_0  = 17'(bb_a[0]);
        bus.in_1  = 9'(bb_b[0]);
        last_cyc  = 0;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus.data_valid && k < 60);
            chk($sformatf("b2b%0d data_valid", i), int'(bus.data_valid), 1);
            model(bb_a[i], bb_b[i], q, r, dz, ov);
            chk($sformatf("b2b%0d quotient", i), act_q(), q);
            chk($sformatf("b2b%0d remainder", i), act_r(), r);
            chk($sformatf("b2b%0d div_by_zero", i), int'(bus.div_by_zero), int'(dz));
            if (i > 0) chk($sformatf("b2b%0d spacing", i), cyc - last_cyc, 19);
            last_cyc = cyc;
            if (i < 3) begin
                bus.in_0 = 17'(bb_a[i+1]);
                bus.in_1 = 9'(bb_b[i+1]);
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b idle_after", int'(bus.busy), 0);

        // Randomized operands against the arithmetic model, biased toward corner cases
        for (int i = 0; i < 150; i++) begin
            int a, b, sel;
            a   = int'($urandom_range(0, 131071)) - 65536;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      b = 0;
            else if (sel == 1) b = ($urandom_range(0, 1) == 0) ? -1 : 1;
            else if (sel == 2) begin
                a = -65536;
                b = int'($urandom_range(0, 511)) - 256;
            end
            else               b = int'($urandom_range(0, 511)) - 256;
            model(a, b, q, r, dz, ov);
            run_div(a, b, q, r, dz, ov, (i % 7) == 0, $sformatf("rnd%0d(%0d/%0d)", i, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
